// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin sharing of the register-file write port between
// the ALU and LSU, a registered write stage, and a scoreboard of in-flight destinations.
module wb_arbiter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      iss_rs1,
    input  logic [4:0]      iss_rs2,
    output logic            iss_stall,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    output logic            we,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_data,
    output logic [31:0]     busy
);

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LSU = 1'b1
    } grant_t;

    grant_t      last;
    logic [31:0] busy_next;

    // On contention the requester that did not win last time gets the port.
    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (!reset) begin
            alu_ready = alu_valid && (!lsu_valid || last == GNT_LSU);
            lsu_ready = lsu_valid && (!alu_valid || last == GNT_ALU);
        end
    end

    always_comb begin
        iss_stall = iss_valid && (busy[iss_rs1] || busy[iss_rs2] || busy[iss_rd]);
    end

    // Clear is applied before set so a same-edge set of the same bit wins.
    always_comb begin
        busy_next = busy;
        if (we) begin
            busy_next[rd] = 1'b0;
        end
        if (iss_valid && !iss_stall && iss_rd != '0) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last    <= GNT_LSU;
            we      <= 1'b0;
            rd      <= '0;
            rd_data <= '0;
            busy    <= '0;
        end else begin
            busy <= busy_next;
            if (alu_ready) begin
                last    <= GNT_ALU;
                we      <= (alu_rd != '0);
                rd      <= alu_rd;
                rd_data <= alu_data;
            end else if (lsu_ready) begin
                last    <= GNT_LSU;
                we      <= (lsu_rd != '0);
                rd      <= lsu_rd;
                rd_data <= lsu_data;
            end else begin
                we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_wb_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            iss_valid;
    logic [4:0]      iss_rd, iss_rs1, iss_rs2;
    logic            iss_stall;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            lsu_valid;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
    logic [31:0]     busy;

    int total = 0;
    int bad   = 0;

    wb_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_stall(iss_stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .we(we), .rd(rd), .rd_data(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who won last, the pending write, and the set of outstanding registers.
    bit          model_ok = 0;
    bit          m_last_lsu;
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    bit          m_busy [32];

    always @(negedge clk) begin
        bit          want_a, want_l, exp_a, exp_l, exp_stall;
        logic [31:0] busy_vec;
        if (model_ok) begin
            want_a = alu_valid;
            want_l = lsu_valid;
            if (reset) begin
                exp_a = 0;
                exp_l = 0;
            end else if (want_a && want_l) begin
                exp_a = m_last_lsu;
                exp_l = !m_last_lsu;
            end else begin
                exp_a = want_a;
                exp_l = want_l;
            end
            exp_stall = iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd]);
            for (int i = 0; i < 32; i++) busy_vec[i] = m_busy[i];
            chk("m_alu_ready", 32'(alu_ready), 32'(exp_a));
            chk("m_lsu_ready", 32'(lsu_ready), 32'(exp_l));
            chk("m_iss_stall", 32'(iss_stall), 32'(exp_stall));
            chk("m_we",        32'(we),        32'(m_we));
            chk("m_busy",      busy,           busy_vec);
            if (m_we) begin
                chk("m_rd",      32'(rd), 32'(m_rd));
                chk("m_rd_data", rd_data, m_data);
            end
        end
        if (reset) begin
            model_ok   = 1;
            m_last_lsu = 1;
            m_we       = 0;
            m_rd       = 0;
            m_data     = 0;
            foreach (m_busy[i]) m_busy[i] = 0;
        end else if (model_ok) begin
            if (m_we) m_busy[m_rd] = 0;
            if (exp_stall == 0 && iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
            if (exp_a) begin
                m_last_lsu = 0; m_we = (alu_rd != 0); m_rd = alu_rd; m_data = alu_data;
            end else if (exp_l) begin
                m_last_lsu = 1; m_we = (lsu_rd != 0); m_rd = lsu_rd; m_data = lsu_data;
            end else begin
                m_we = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    endtask

    initial begin
        int ai, li;
        bit acc_a, acc_l;
        reset = 1;
        idle_inputs();
        step(); step();
        @(negedge clk);
        chk("rst_we", 32'(we), 32'h0);
        chk("rst_rd", 32'(rd), 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_busy", busy, 32'h0);

        // Single ALU write
        step();
        reset = 0;
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("single_alu_ready", 32'(alu_ready), 32'h1);
        chk("single_lsu_ready", 32'(lsu_ready), 32'h0);
        step();
        alu_valid = 0;
        @(negedge clk);
        chk("single_we", 32'(we), 32'h1);
        chk("single_rd", 32'(rd), 32'd5);
        chk("single_data", rd_data, 32'hDEADBEEF);
        chk("single_lsu_ready1", 32'(lsu_ready), 32'h0);

        // Continuous contention after reset: ALU, LSU, ALU, LSU
        step();
        reset = 1;
        step();
        reset = 0;
        ai = 0; li = 0;
        alu_valid = 1; alu_rd = 1; alu_data = 32'hA000_0001;
        lsu_valid = 1; lsu_rd = 2; lsu_data = 32'hB000_0002;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 4) begin
                chk("rr_alu_ready", 32'(alu_ready), 32'((k % 2) == 0));
                chk("rr_lsu_ready", 32'(lsu_ready), 32'((k % 2) == 1));
            end
            if (k > 0) begin
                chk("rr_we", 32'(we), 32'h1);
                chk("rr_rd", 32'(rd), 32'(k));
                chk("rr_data", rd_data, ((k % 2) == 1 ? 32'hA000_0000 : 32'hB000_0000) | 32'(k));
            end
            step();
            if (k % 2 == 0) begin
                ai++;
                alu_rd = 5'(2 * ai + 1); alu_data = 32'hA000_0000 | 32'(2 * ai + 1);
            end else begin
                li++;
                lsu_rd = 5'(2 * li + 2); lsu_data = 32'hB000_0000 | 32'(2 * li + 2);
            end
            if (k >= 3) begin
                alu_valid = 0; lsu_valid = 0;
            end
        end

        // RAW stall on x7, released by an LSU write
        iss_valid = 1; iss_rd = 7; iss_rs1 = 0; iss_rs2 = 0;
        @(negedge clk);
        chk("raw_issue_stall", 32'(iss_stall), 32'h0);
        step();
        iss_rd = 0; iss_rs1 = 7;
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
        @(negedge clk);
        chk("raw_busy_t", busy, 32'h80);
        chk("raw_stall_t", 32'(iss_stall), 32'h1);
        chk("raw_lsu_ready", 32'(lsu_ready), 32'h1);
        step();
        lsu_valid = 0;
        @(negedge clk);
        chk("raw_we_t1", 32'(we), 32'h1);
        chk("raw_rd_t1", 32'(rd), 32'd7);
        chk("raw_stall_t1", 32'(iss_stall), 32'h1);
        step();
        @(negedge clk);
        chk("raw_busy_t2", busy, 32'h0);
        chk("raw_stall_t2", 32'(iss_stall), 32'h0);

        // rd = 0 write and x0 issue
        step();
        iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
        alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
        @(negedge clk);
        chk("x0_alu_ready", 32'(alu_ready), 32'h1);
        chk("x0_stall", 32'(iss_stall), 32'h0);
        step();
        alu_valid = 0;
        iss_rd = 3;
        @(negedge clk);
        chk("x0_we", 32'(we), 32'h0);
        chk("x0_busy", busy, 32'h0);
        chk("waw_first_stall", 32'(iss_stall), 32'h0);
        step();
        @(negedge clk);
        chk("waw_stall", 32'(iss_stall), 32'h1);
        chk("waw_busy", busy, 32'h8);
        step();
        @(negedge clk);
        chk("waw_busy_hold", busy, 32'h8);

        // Reset in the cycle after a grant
        step();
        iss_valid = 0;
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        @(negedge clk);
        chk("mid_grant", 32'(alu_ready), 32'h1);
        step();
        reset = 1;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h44;
        @(negedge clk);
        chk("mid_alu_ready_rst", 32'(alu_ready), 32'h0);
        chk("mid_lsu_ready_rst", 32'(lsu_ready), 32'h0);
        step();
        reset = 0;
        @(negedge clk);
        chk("mid_we", 32'(we), 32'h0);
        chk("mid_busy", busy, 32'h0);
        chk("mid_alu_first", 32'(alu_ready), 32'h1);
        chk("mid_lsu_first", 32'(lsu_ready), 32'h0);
        step();
        idle_inputs();

        // Randomized traffic under the handshake rules
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc_a = alu_valid && alu_ready;
            acc_l = lsu_valid && lsu_ready;
            step();
            reset = ($urandom_range(199) == 0);
            if (!alu_valid || acc_a) begin
                alu_valid = ($urandom_range(2) != 0);
                alu_rd    = 5'($urandom_range(7));
                alu_data  = $urandom;
            end
            if (!lsu_valid || acc_l) begin
                lsu_valid = ($urandom_range(2) != 0);
                lsu_rd    = 5'($urandom_range(7));
                lsu_data  = $urandom;
            end
            iss_valid = $urandom_range(1) != 0;
            iss_rd    = 5'($urandom_range(7));
            iss_rs1   = 5'($urandom_range(7));
            iss_rs2   = 5'($urandom_range(7));
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and register scoreboard for the integer register file. Shares the single register-file write port between the ALU and load/store writeback paths with round-robin fairness. Registers the winning write one cycle before it reaches the register file. Tracks in-flight destination registers so the issue stage stalls on RAW/WAW hazards. Sits between execute/memory and the register file, alongside decode/issue.

## Interface

- XLEN, 32, data width of register-file writes
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- iss_valid  in  1  issue stage presents an instruction
- iss_rd  in  5  destination register of issuing instruction (0 = no write)
- iss_rs1, iss_rs2  in  5 each  source registers of issuing instruction
- iss_stall  out  1  combinational hazard stall to issue stage
- alu_valid  in  1  ALU writeback request
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- lsu_valid, lsu_rd, lsu_data  in  1/5/XLEN  load writeback request, same meaning as ALU
- lsu_ready  out  1  load request accepted this cycle
- we  out  1  register-file write enable (registered)
- rd  out  5  register-file write address (registered)
- rd_data  out  XLEN  register-file write data (registered)
- busy  out  32  scoreboard; bit n = write to xn outstanding; bit 0 constant 0

## Operation

- Handshake: request transfers on a cycle with valid && ready. Requester holds valid/rd/data stable until ready. ready never asserts without valid. At most one of alu_ready/lsu_ready is high per cycle.
- Arbitration: one request only -> granted. Both requests -> grant goes to the requester not granted last. A 1-bit `last` register updates only on a grant. Neither valid -> no grant; `last` unchanged.
- Write register: on a grant, next cycle we = (granted rd != 0), rd = granted rd, rd_data = granted data. With no grant, next cycle we = 0; rd and rd_data hold their previous values.
- rd = 0 request: accepted normally (ready asserts). we stays 0. Scoreboard untouched.
- Scoreboard set: on iss_valid && !iss_stall && iss_rd != 0, busy[iss_rd] <= 1.
- Scoreboard clear: when we = 1, busy[rd] <= 0 at the end of that cycle. This is the same edge the register file captures the data.
- Set and clear of the same bit on the same edge: set wins.
- iss_stall = iss_valid && (busy[iss_rs1] || busy[iss_rs2] || busy[iss_rd]). busy[0] is always 0, so x0 never stalls.
- No forwarding. A consumer issues the cycle after busy clears and reads the committed value directly from the register file.
- Requests without a matching scoreboard entry are legal. They write normally, and the clear is a no-op.

## Timing

- ready: combinational from valid and `last`. No dependency on iss_*.
- iss_stall: combinational from iss_* and busy.
- Write latency: grant in cycle t -> we/rd/rd_data valid in cycle t+1 -> register file updated at end of t+1. busy bit low in t+2.
- Minimum issue-to-dependent-issue spacing: producer granted in cycle t, dependent issue no earlier than t+2.
- Throughput: one write per cycle. Under continuous contention, grants alternate ALU, LSU, ALU, ...
- Reset values: we = 0, rd = 0, rd_data = 0, busy = 0, last = LSU (so the ALU wins the first contention).
- Reset mid-operation: a registered write pending for the next cycle is dropped (we = 0). All busy bits clear. While reset is high, alu_ready = lsu_ready = 0.

## Test plan

- Reset, then a single ALU write rd = 5, data = 0xDEADBEEF: alu_ready high in cycle 0; cycle 1 we = 1, rd = 5, rd_data = 0xDEADBEEF; lsu_ready stays 0.
- Both valid for 4 consecutive cycles after reset: grant sequence ALU, LSU, ALU, LSU. The loser holds valid. we high in each of cycles 1-4 with matching rd/data.
- Issue rd = 7, then issue rs1 = 7 in the next cycle: iss_stall = 1 while busy[7] = 1. LSU writes x7 (grant t, we in t+1). Stall drops and busy[7] = 0 in t+2.
- Request with rd = 0, data = 0x1234: ready asserts; next cycle we = 0. Issue with rd = rs1 = rs2 = 0 never stalls.
- WAW: issue rd = 3 while busy[3] = 1 -> iss_stall = 1, and busy stays at the single outstanding entry.
- Assert reset in the cycle after a grant: we = 0 next cycle, busy = 0, both ready = 0 during reset. The first post-reset contention grants the ALU.
